// File: rtl/video_pixel_tx.sv
// Camera-style pixel transmitter: generates FRAME_VALID/LINE_VALID timing and emits
// either an internal x+16*y test pattern or pixels pulled from an Avalon-ST sink.
module video_pixel_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 20000,
    parameter int FV_LEAD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pattern_mode,
    input  logic        underflow_clr,
    input  logic [11:0] sink_data,
    input  logic        sink_valid,
    output logic        sink_ready,
    output logic [11:0] PIXEL_DATA,
    output logic        LINE_VALID,
    output logic        FRAME_VALID,
    output logic [15:0] frame_count,
    output logic        underflow,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_ACTIVE, S_HBLANK, S_TRAIL, S_VBLANK
    } state_t;

    // Last-cycle markers; a zero-length parameter never reaches its compare.
    localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
    localparam logic [15:0] FV_LAST = 16'(FV_LEAD - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        mode_q, mode_d;
    logic [11:0] pixel_q, pixel_d;
    logic        lv_q, lv_d;
    logic        fv_q, fv_d;
    logic [15:0] fc_q, fc_d;
    logic        uf_q, uf_d;

    logic line_end, frame_done, new_frame, active;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        mode_d     = mode_q;
        frame_done = 1'b0;
        new_frame  = 1'b0;
        line_end   = (x_q == X_LAST);

        case (state_q)
            S_IDLE:   if (enable) begin
                          state_d   = S_LEAD;
                          new_frame = 1'b1;
                      end
            S_LEAD:   if (cnt_q == FV_LAST) state_d = S_ACTIVE;
            S_ACTIVE: if (line_end) begin
                          if (y_q < Y_LAST) begin
                              state_d = S_HBLANK;
                              y_d     = y_q + 16'd1;
                          end else begin
                              state_d = S_TRAIL;
                          end
                      end
            S_HBLANK: if (cnt_q == HB_LAST) state_d = S_ACTIVE;
            S_TRAIL:  if (cnt_q == FV_LAST) begin
                          state_d    = S_VBLANK;
                          frame_done = 1'b1;
                      end
            S_VBLANK: if (cnt_q == VB_LAST) begin
                          state_d   = enable ? S_LEAD : S_IDLE;
                          new_frame = enable;
                      end
            default:  state_d = S_IDLE;
        endcase

        // Zero-length states are skipped; order matters because one skip can lead into another.
        if (state_d == S_TRAIL && FV_LEAD == 0) begin
            state_d    = S_VBLANK;
            frame_done = 1'b1;
        end
        if (state_d == S_VBLANK && V_BLANK == 0) begin
            state_d   = enable ? S_LEAD : S_IDLE;
            new_frame = enable;
        end
        if (state_d == S_LEAD && FV_LEAD == 0) state_d = S_ACTIVE;
        if (state_d == S_HBLANK && H_BLANK == 0) state_d = S_ACTIVE;

        if (new_frame) begin
            mode_d = pattern_mode;
            y_d    = 16'd0;
        end

        x_d   = (state_q == S_ACTIVE && !line_end) ? x_q + 16'd1 : 16'd0;
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    assign active = (state_q == S_ACTIVE);

    always_comb begin
        fv_d = (state_q == S_LEAD) || (state_q == S_ACTIVE) ||
               (state_q == S_HBLANK) || (state_q == S_TRAIL);
        lv_d = active;
        if (!active)
            pixel_d = 12'd0;
        else if (mode_q)
            pixel_d = x_q[11:0] + {y_q[7:0], 4'd0};
        else
            pixel_d = sink_valid ? sink_data : 12'd0;
        // Set wins over clear so an underflow in the clear cycle is never lost.
        uf_d = (active && !mode_q && !sink_valid) || (uf_q && !underflow_clr);
        fc_d = fc_q + 16'(frame_done);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            mode_q  <= 1'b0;
            pixel_q <= 12'd0;
            lv_q    <= 1'b0;
            fv_q    <= 1'b0;
            fc_q    <= 16'd0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            pixel_q <= pixel_d;
            lv_q    <= lv_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
            uf_q    <= uf_d;
        end
    end

    assign PIXEL_DATA  = pixel_q;
    assign LINE_VALID  = lv_q;
    assign FRAME_VALID = fv_q;
    assign frame_count = fc_q;
    assign underflow   = uf_q;
    assign sink_ready  = active && !mode_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/video_pixel_tx.md
VIDEO_PIXEL_TX -- requirements
Module: video_pixel_tx

Interface
REQ-001 Parameters (name, default, meaning):
  H_ACTIVE, 640, pixels per line;
  H_BLANK, 160, LINE_VALID-low cycles between lines inside a frame;
  V_ACTIVE, 480, lines per frame;
  V_BLANK, 20000, FRAME_VALID-low cycles between frames;
  FV_LEAD, 2, FRAME_VALID-high cycles before the first line and after the last line.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  sole clock;
  reset  in  1  synchronous, active-high;
  enable  in  1  start/continue frame generation;
  pattern_mode  in  1  1 = internal test pattern, 0 = stream sink;
  underflow_clr  in  1  clears underflow;
  sink_data  in  12  Avalon-ST pixel data;
  sink_valid  in  1  sink valid;
  sink_ready  out  1  sink ready;
  PIXEL_DATA  out  12  camera-format pixel;
  LINE_VALID  out  1  active line;
  FRAME_VALID  out  1  active frame;
  frame_count  out  16  completed frames;
  underflow  out  1  sticky underflow flag;
  busy  out  1  state not IDLE.
REQ-003 Reset is synchronous and active-high on the single clock clk; there are no other clock domains.
REQ-004 PIXEL_DATA, LINE_VALID, FRAME_VALID, frame_count and underflow SHALL be registered; sink_ready and busy SHALL be decoded combinationally from registered state only.

Function
REQ-005 FSM states: IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK.
REQ-006 IDLE: when enable=1, go to LEAD, latch pattern_mode for the whole frame, and clear x and y.
REQ-007 LEAD lasts FV_LEAD cycles, then goes to ACTIVE.
REQ-008 ACTIVE lasts H_ACTIVE cycles, with x counting 0..H_ACTIVE-1. On exit:
  if y<V_ACTIVE-1, go to HBLANK and increment y;
  otherwise go to TRAIL.
REQ-009 HBLANK lasts H_BLANK cycles, then goes to ACTIVE with x=0.
REQ-010 TRAIL lasts FV_LEAD cycles, then goes to VBLANK and increments frame_count, wrapping 0xFFFF->0.
REQ-011 VBLANK lasts V_BLANK cycles. On exit: if enable=1, go to LEAD (new frame); otherwise go to IDLE.
REQ-012 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame always completes and the block stops after VBLANK.
REQ-013 FRAME_VALID(t+1) SHALL be 1 iff state(t) is LEAD, ACTIVE, HBLANK or TRAIL.
REQ-014 LINE_VALID(t+1) SHALL be 1 iff state(t)=ACTIVE.
REQ-015 Net output timing: each line is exactly H_ACTIVE LINE_VALID-high cycles; each frame is exactly V_ACTIVE lines; every output edge is one cycle after the corresponding state edge.
REQ-016 sink_ready SHALL be 1 iff state=ACTIVE and the latched pattern_mode=0.
REQ-017 In ACTIVE with pattern_mode=0:
  sink_valid=1: PIXEL_DATA(t+1)=sink_data(t), and the beat is consumed;
  sink_valid=0: PIXEL_DATA(t+1)=0 and underflow is set; the timing generator never stalls.
REQ-018 In ACTIVE with pattern_mode=1: PIXEL_DATA(t+1) = (x + 16*y) mod 4096, 12-bit wrap; sink_ready stays 0.
REQ-019 Outside ACTIVE, PIXEL_DATA SHALL be driven to 0.
REQ-020 underflow is sticky and set-dominant: if underflow_clr=1 and an underflow occur in the same cycle, underflow remains 1.
REQ-021 All blank and lead counters SHALL be 16 bits wide; parameter values of 0 for H_BLANK, V_BLANK or FV_LEAD SHALL skip that state (zero cycles).

Reset
REQ-022 Reset SHALL drive state=IDLE, x=y=0, and PIXEL_DATA=0, LINE_VALID=0, FRAME_VALID=0, frame_count=0, underflow=0, sink_ready=0, busy=0 on the next clk edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately: FRAME_VALID and LINE_VALID are 0 the cycle after reset is sampled, and no partial frame is counted.

Verification
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=3, FV_LEAD=1.
REQ-024 Test pattern: reset, then enable=1 and pattern_mode=1 for one frame.
  Expect FRAME_VALID high for 12 cycles: 1 lead, 4 LV, 2 blank, 4 LV, 1 trail.
  Expect PIXEL_DATA 0,1,2,3 then 16,17,18,19, followed by FRAME_VALID low for 3 cycles and frame_count=1.
REQ-025 Stream mode: pattern_mode=0, sink_valid held 1, sink_data = 0xA00 incrementing per handshake.
  Expect exactly 8 handshakes per frame, PIXEL_DATA 0xA00..0xA07 each one cycle after its handshake, and underflow=0.
REQ-026 Underflow: in stream mode, drop sink_valid during the 3rd pixel of line 0.
  Expect PIXEL_DATA=0 for that pixel, underflow=1, and line timing unchanged.
  Pulsing underflow_clr during VBLANK clears underflow to 0.
REQ-027 Enable drop: deassert enable during line 0 of frame 1.
  Expect that frame to complete fully and frame_count=2; then state returns to IDLE, busy=0, and no further FRAME_VALID.
REQ-028 Mid-frame reset: assert reset during the HBLANK of line 0.
  Expect LINE_VALID=0, FRAME_VALID=0 and frame_count=0 on the next cycle.
  Expect a clean frame to restart after reset is released with enable=1.
REQ-029 frame_count wrap: preload via 65535 short frames (or force).
  Expect the next frame completion to give frame_count=0.
